serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single one-bit full-adder datapath over WIDTH-bit operands, least significant bit (LSB) first, one bit per clock. It sits between a requester and the one-bit full-adder cell. It latches the operands on a start handshake, iterates the carry through a carry flip-flop, and returns a registered sum with carry-out and signed-overflow flags. It is the sequential wrapper that turns the lab full adder into a multi-bit arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a rising edge while in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled only on the acceptance edge.
- b  in  WIDTH  operand B; sampled only on the acceptance edge.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; result outputs valid.
- sum  out  WIDTH  result, registered.
- co  out  1  final carry-out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low.
- FSM states:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH bit steps.
  - DONE -> IDLE unconditionally.
- Acceptance (IDLE, start=1):
  - opa <= a.
  - opb <= sub ? ~b : b.
  - carry <= sub.
  - cnt <= 0.
  - acc <= 0.
- RUN, per cycle:
  - Full adder on opa[0], opb[0], carry: s = opa[0]^opb[0]^carry; c' = majority(opa[0], opb[0], carry).
  - Shift opa and opb right by 1.
  - Shift s into acc at the MSB side, so after WIDTH steps acc[WIDTH-1:0] is the result in order.
  - carry <= c'; cnt <= cnt+1.
  - On the step where cnt = WIDTH-1, record cin_msb = carry (the carry into the MSB).
- RUN -> DONE edge:
  - sum <= final acc, co <= c', ovf <= cin_msb ^ c'.
  - These are the only edges on which sum, co and ovf change; they are held otherwise.
- start is ignored in RUN and DONE; no queuing.
- Changes on a, b or sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - busy=0, done=0, sum=0, co=0, ovf=0.
  - All internal registers 0.
- Acceptance edge k: busy=1 from edge k through edge k+WIDTH (WIDTH cycles).
- Edge k+WIDTH: busy=0, done=1, new sum, co and ovf visible.
- Edge k+WIDTH+1: done=0, state IDLE.
- The earliest next acceptance is edge k+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- busy and done are never high together; done is never high for more than one cycle.
- Reset mid-RUN or in DONE:
  - Immediate abort; no done pulse.
  - Outputs cleared to 0.
  - After rst_n rises, the first start is accepted normally.
- start held high continuously: one operation per WIDTH+2 cycles, re-accepted in each IDLE cycle.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, sum=0x00, co=0, ovf=0 immediately, before the next clock edge.
- Add, WIDTH=8, a=0x5A, b=0x3C, sub=0 -> done exactly 8 cycles after the acceptance edge; sum=0x96, co=0, ovf=1; busy high for exactly 8 cycles.
- Add wrap, a=0xFF, b=0x01 -> sum=0x00, co=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, co=0, ovf=1.
- Subtract, a=0x10, b=0x20, sub=1 -> sum=0xF0, co=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, co=1, ovf=1.
- Handshake:
  - Hold start=1 and change a/b every cycle during RUN -> result reflects only the operands present at the acceptance edge.
  - The second acceptance lands exactly WIDTH+2 cycles after the first.
  - sum is held stable between done pulses.
- Abort: start a=0x5A, b=0x3C, then pull rst_n low after 4 RUN cycles -> no done pulse, sum=0x00. Release reset, then start a=0x01, b=0x02 -> sum=0x03, co=0, ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract over WIDTH-bit operands, LSB first, one bit per clock.
// Latency: result and done appear WIDTH cycles after the acceptance edge; one op per WIDTH+2 cycles.
// Backpressure: none queued; start is only accepted in IDLE, ignored while RUN or DONE.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, sub     request strobe and operation select (0 = a+b, 1 = a-b), sampled on acceptance
//   a, b           WIDTH-bit operands, sampled on acceptance only
//   busy, done     busy while bits are processed; done is a one-cycle result-valid pulse
//   sum, co, ovf   registered result, carry-out (1 = no borrow on subtract), signed overflow
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  // One-bit full adder cell on the current LSBs and the carry flop.
  logic fa_s;
  logic fa_c;
  assign fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert B and seed the carry with 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB step carry_q is the carry into the MSB, so the
          // overflow flag can be formed directly without a separate flop.
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          co_d    = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int passed = 0;
  int total  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Reference arithmetic from plain integer math: returns {ovf, co, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    int ux, uy, sx, sy, r;
    logic [W-1:0] res;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
    if (s) begin
      res = W'(ux - uy);
      c   = (ux >= uy);
      r   = sx - sy;
    end else begin
      res = W'(ux + uy);
      c   = ((ux + uy) >= (1 << W));
      r   = sx + sy;
    end
    v = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    return {v, c, res};
  endfunction

  // Behavioural model: t counts edges since acceptance (-1 = idle).
  int           m_t;
  logic [W+1:0] m_pend;
  logic [W-1:0] m_sum;
  logic         m_co;
  logic         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t   <= -1;
      m_sum <= '0;
      m_co  <= 1'b0;
      m_ovf <= 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t    <= 0;
        m_pend <= ref_op(a, b, sub);
      end
    end else if (m_t == W) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == W) begin
        m_sum <= m_pend[W-1:0];
        m_co  <= m_pend[W];
        m_ovf <= m_pend[W+1];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", busy, (m_t >= 0 && m_t < W));
      chk("cyc_done", done, (m_t == W));
      chk("cyc_sum", sum, m_sum);
      chk("cyc_co", co, m_co);
      chk("cyc_ovf", ovf, m_ovf);
      chk("cyc_busy_done_excl", busy & done, 1'b0);
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       input logic [W-1:0] es, input logic eco, input logic eovf,
                       input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts;
    chk({nm, "_busy"}, busy, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_co"}, co, eco);
    chk({nm, "_ovf"}, ovf, eovf);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    bit seen_low;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    // Pin the reference arithmetic itself.
    chk("model_5a_3c", ref_op(8'h5A, 8'h3C, 1'b0), {1'b1, 1'b0, 8'h96});
    chk("model_80_m1", ref_op(8'h80, 8'h01, 1'b1), {1'b1, 1'b1, 8'h7F});
    chk("model_10_m20", ref_op(8'h10, 8'h20, 1'b1), {1'b0, 1'b0, 8'hF0});

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 8'h00);
    #2 rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");

    // Asynchronous reset mid-cycle with co=1 showing.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_sum", sum, 8'h00);
    chk("arst_co", co, 1'b0);
    chk("arst_ovf", ovf, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

    // start held high with operands churning every cycle.
    @(negedge clk);
    start = 1'b1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    n = 0;
    while (!busy && n < 5) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      n++;
    end
    chk("hold_first_accept", busy, 1'b1);
    n = 0;
    seen_low = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      n++;
      if (!busy) seen_low = 1'b1;
      else if (seen_low) break;
    end
    chk("hold_accept_spacing", n, W + 2);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Abort mid-RUN.
    a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", sum, 8'h00);
    repeat (W) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    #2 rst_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "post_abort");

    // Randomized traffic, occasional async reset; checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
